rvm_sensor_filter: RTL
======================

RVM_SENSOR_FILTER -- requirements
Module: rvm_sensor_filter

Interface
REQ-001 Parameter: NUM_SENSORS, 4, number of independent sensor channels.
REQ-002 Parameter: DEBOUNCE_CYCLES, 1_000_000, consecutive mismatch cycles needed to accept a new level (10 ms at 100 MHz); legal range 1 .. 2^CNT_W.
REQ-003 Parameter: CNT_W, 20, qualify-counter width.
REQ-004 Port: clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: sensor_raw  input  NUM_SENSORS  asynchronous, bouncing sensor inputs from board pins.
REQ-007 Port: sensor_clean  output  NUM_SENSORS  debounced sensor level; feeds the RVM controller's sensor input.
REQ-008 Port: sensor_rise  output  NUM_SENSORS  one-cycle pulse per channel when sensor_clean goes 0->1.
REQ-009 Port: sensor_fall  output  NUM_SENSORS  one-cycle pulse per channel when sensor_clean goes 1->0.

Function
REQ-010 Each sensor_raw bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-011 Each channel SHALL run an independent 2-state FSM: STABLE (sync2 == clean, counter held at 0) and QUALIFY (sync2 != clean, counter incrementing).
REQ-012 STABLE->QUALIFY SHALL occur on the first edge where sync2 != clean; the counter SHALL then hold 1 if DEBOUNCE_CYCLES > 1.
REQ-013 In QUALIFY, an edge where sync2 == clean SHALL return the channel to STABLE with counter 0, with no change to clean and no pulse (glitch rejection).
REQ-014 The channel SHALL complement clean, clear the counter and enter STABLE on the edge that completes DEBOUNCE_CYCLES consecutive mismatching cycles; DEBOUNCE_CYCLES == 1 SHALL update on the first mismatch edge.
REQ-015 Latency: a raw level first sampled at edge k and held SHALL appear on sensor_clean at edge k+1+DEBOUNCE_CYCLES (2 sync stages + qualification).
REQ-016 sensor_rise/sensor_fall SHALL be registered, asserted for exactly the one cycle following the edge where clean changes, and never both high for the same bit.
REQ-017 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL NOT wrap.
REQ-018 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce pulses in the same cycle.
REQ-019 A raw input toggling faster than DEBOUNCE_CYCLES SHALL produce no clean change and no pulses for the duration of the bouncing.

Reset
REQ-020 While reset is high, sync1, sync2, sensor_clean, sensor_rise, sensor_fall and all counters SHALL be 0 and all FSMs in STABLE on the next edge.
REQ-021 Reset asserted mid-QUALIFY SHALL abort qualification with no pulse; a raw input still high after release SHALL requalify from scratch (full REQ-015 latency).
REQ-022 The first clean 0->1 after reset SHALL produce a normal sensor_rise pulse.

Structure
REQ-023 Shared package rvm_pkg SHALL hold NUM_SENSORS, the default DEBOUNCE_CYCLES and CNT_W, and the per-channel state enumeration (STABLE, QUALIFY).
REQ-024 One sub-module, rvm_debounce_ch (single channel: synchronizer, FSM, counter, edge pulses), SHALL be instantiated NUM_SENSORS times by generate loop; the top has no other logic.

Verification (DEBOUNCE_CYCLES = 8 for simulation)
REQ-025 reset=1 with raw=1111 for 5 cycles -> clean=0000, no pulses; reset release at edge r -> clean=1111 and rise=1111 for one cycle at edge r+9.
REQ-026 raw[0]=1 for 5 cycles then 0 -> clean[0] stays 0, rise[0] never asserted.
REQ-027 raw[0]=1 held from edge k -> clean[0]=1 at edge k+9, rise[0] high exactly one cycle; other bits unchanged.
REQ-028 raw[3] toggled every 3 cycles for 30 cycles then held high -> exactly one rise[3], 9 edges after the final raw transition.
REQ-029 clean=1001 stable, raw -> 0000 -> fall=1001 asserted in the same single cycle, clean=0000.
REQ-030 reset pulsed while channel 1 counter = 5 -> no pulse, clean[1]=0; raw[1] still high -> rise[1] 9 edges after reset release.

Source files
------------

// File: rtl/rvm_pkg.sv
// rtl/rvm_pkg.sv - shared constants and per-channel state type for the sensor filter
package rvm_pkg;

  localparam int RVM_NUM_SENSORS     = 4;
  localparam int RVM_DEBOUNCE_CYCLES = 1_000_000;
  localparam int RVM_CNT_W           = 20;

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } ch_state_e;

endpackage

// File: rtl/rvm_debounce_ch.sv
// rtl/rvm_debounce_ch.sv - one sensor channel: 2-flop synchronizer, qualify FSM, edge pulses
module rvm_debounce_ch
  import rvm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = RVM_DEBOUNCE_CYCLES,
  parameter int CNT_W           = RVM_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             clean_q, clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ch_state_e        state_q, state_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (sync2_q != clean_q) begin
          if (CNT_LAST == '0) begin
            clean_d = ~clean_q;
            rise_d  = ~clean_q;
            fall_d  = clean_q;
          end else begin
            state_d = QUALIFY;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      QUALIFY: begin
        // A single matching sample throws away the whole qualification run.
        if (sync2_q == clean_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE;
          cnt_d   = '0;
          clean_d = ~clean_q;
          rise_d  = ~clean_q;
          fall_d  = clean_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= STABLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/rvm_sensor_filter.sv
// rtl/rvm_sensor_filter.sv - array of independent debounce channels for the RVM sensor inputs
module rvm_sensor_filter
  import rvm_pkg::*;
#(
  parameter int NUM_SENSORS     = RVM_NUM_SENSORS,
  parameter int DEBOUNCE_CYCLES = RVM_DEBOUNCE_CYCLES,
  parameter int CNT_W           = RVM_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SENSORS-1:0] sensor_raw,
  output logic [NUM_SENSORS-1:0] sensor_clean,
  output logic [NUM_SENSORS-1:0] sensor_rise,
  output logic [NUM_SENSORS-1:0] sensor_fall
);

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
    rvm_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (sensor_raw[i]),
      .clean(sensor_clean[i]),
      .rise (sensor_rise[i]),
      .fall (sensor_fall[i])
    );
  end

endmodule
